// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fwd_pkg
// Description : Shared types and default constants for the forwarding /
//               hazard unit. Holds the shadow-pipeline entry struct, the
//               default parameter values and the default zero register.
// Revision    : 1.0 - initial release
// ============================================================================
package fwd_pkg;

  localparam int NRD_DEF    = 3;   // decode read ports
  localparam int NST_DEF    = 3;   // forwardable stages (1=EX, 2=MEM, 3=WR)
  localparam int AW_DEF     = 5;   // register address width
  localparam int ZR_DEF     = 31;  // zero register, never forwarded
  localparam int LD_LAT_DEF = 1;   // stages where a load result is not ready
  localparam int CW_DEF     = 16;  // load-use counter width

  // Entries store addresses zero-extended to AW_MAX bits so one struct type
  // serves every AW setting; AW must not exceed AW_MAX.
  localparam int AW_MAX = 8;

  typedef struct packed {
    logic              valid;
    logic [AW_MAX-1:0] rd;
    logic              regwrite;
    logic              memread;
  } shadow_t;

endpackage : fwd_pkg
`default_nettype wire

// File: rtl/fwd_port_match.sv
`default_nettype none
// ============================================================================
// Module      : fwd_port_match
// Description : Priority match of one decode read port against the shadow
//               pipeline. Reports the youngest matching stage and whether the
//               match hits a load whose data is not yet forwardable.
// Ports       : rs_addr  - source register of this port
//               rs_used  - port actually reads its register
//               entries  - shadow entries, entries[k-1] mirrors stage k
//               sel      - 0 = register file, k = forward from stage k
//               lu_hit   - port matches a not-yet-ready load result
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_port_match
  import fwd_pkg::*;
#(
  parameter int NST    = NST_DEF,
  parameter int AW     = AW_DEF,
  parameter int ZR     = ZR_DEF,
  parameter int LD_LAT = LD_LAT_DEF,
  parameter int SW     = $clog2(NST + 1)
) (
  input  logic                  [AW-1:0] rs_addr,
  input  logic                           rs_used,
  input  shadow_t              [NST-1:0] entries,
  output logic                  [SW-1:0] sel,
  output logic                           lu_hit
);

  logic [AW_MAX-1:0] w_addr;
  logic [NST-1:0]    w_match;

  assign w_addr = AW_MAX'(rs_addr);

  generate
    for (genvar k = 0; k < NST; k++) begin : g_match
      // A destination of ZR is kept in the entry but can never be a source
      // of forwarded data.
      assign w_match[k] = rs_used
                        && entries[k].valid
                        && entries[k].regwrite
                        && (entries[k].rd == w_addr)
                        && (entries[k].rd != AW_MAX'(ZR));
    end
  endgenerate

  always_comb begin
    sel    = '0;
    lu_hit = 1'b0;
    // Scan oldest to youngest so the youngest match overwrites the rest.
    for (int k = NST - 1; k >= 0; k--) begin
      if (w_match[k]) begin
        sel = SW'(k + 1);
      end
    end
    for (int k = 0; k < NST; k++) begin
      if (w_match[k] && entries[k].memread && (k < LD_LAT)) begin
        lu_hit = 1'b1;
      end
    end
  end

endmodule : fwd_port_match
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_unit
// Description : Operand forwarding select and load-use hazard detection for
//               an in-order pipeline. A shadow pipeline of NST entries tracks
//               the destination of every instruction downstream of decode.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               issue_*           - instruction currently in decode
//               rs_addr / rs_used - decode read ports
//               flush             - squash the decode instruction
//               ext_stall         - global pipeline freeze
//               fwd_sel           - per-port forwarding source (0 = regfile)
//               stall_dec         - hold PC and decode this cycle
//               bubble_ex         - NOP enters stage 1 at the next edge
//               lu_count          - saturating count of load-use bubbles
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NRD    = NRD_DEF,
  parameter int NST    = NST_DEF,
  parameter int AW     = AW_DEF,
  parameter int ZR     = ZR_DEF,
  parameter int LD_LAT = LD_LAT_DEF,
  parameter int CW     = CW_DEF,
  localparam int SW    = $clog2(NST + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     issue_valid,
  input  logic [AW-1:0]            issue_rd,
  input  logic                     issue_regwrite,
  input  logic                     issue_memread,
  input  logic [NRD-1:0][AW-1:0]   rs_addr,
  input  logic [NRD-1:0]           rs_used,
  input  logic                     flush,
  input  logic                     ext_stall,
  output logic [NRD-1:0][SW-1:0]   fwd_sel,
  output logic                     stall_dec,
  output logic                     bubble_ex,
  output logic [CW-1:0]            lu_count
);

  shadow_t [NST-1:0]         r_shadow;
  logic    [NRD-1:0][SW-1:0] w_sel;
  logic    [NRD-1:0]         w_lu_port;
  logic                      w_load_use;
  shadow_t                   w_issue;

  generate
    for (genvar p = 0; p < NRD; p++) begin : g_port
      fwd_port_match #(
        .NST    (NST),
        .AW     (AW),
        .ZR     (ZR),
        .LD_LAT (LD_LAT),
        .SW     (SW)
      ) u_match (
        .rs_addr (rs_addr[p]),
        .rs_used (rs_used[p]),
        .entries (r_shadow),
        .sel     (w_sel[p]),
        .lu_hit  (w_lu_port[p])
      );

      // A port waiting on a load must not pick up the stale stage value.
      assign fwd_sel[p] = (issue_valid && w_lu_port[p]) ? '0 : w_sel[p];
    end
  endgenerate

  assign w_load_use = issue_valid && (|w_lu_port);
  assign stall_dec  = ext_stall || (w_load_use && !flush);
  // A flush always bubbles; a freeze suppresses any bubble since nothing moves.
  assign bubble_ex  = !ext_stall && (w_load_use || flush || !issue_valid);

  assign w_issue = '{valid:    1'b1,
                     rd:       AW_MAX'(issue_rd),
                     regwrite: issue_regwrite,
                     memread:  issue_memread};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow <= '0;
      lu_count <= '0;
    end else if (!ext_stall) begin
      for (int k = NST - 1; k > 0; k--) begin
        r_shadow[k] <= r_shadow[k-1];
      end
      r_shadow[0] <= bubble_ex ? '0 : w_issue;
      if (w_load_use && !flush && (lu_count != {CW{1'b1}})) begin
        lu_count <= lu_count + CW'(1);
      end
    end
  end

endmodule : fwd_hazard_unit
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fwd_hazard_unit
// Description : Self-checking bench for fwd_hazard_unit. Two instances share
//               stimulus (default counter width and a 2-bit counter); both
//               are compared to a stage-list reference model every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_unit;

  localparam int NRD = 3;
  localparam int NST = 3;
  localparam int AW  = 5;
  localparam int ZR  = 31;
  localparam int LDL = 1;
  localparam int SW  = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   issue_valid;
  logic [AW-1:0]          issue_rd;
  logic                   issue_regwrite;
  logic                   issue_memread;
  logic [NRD-1:0][AW-1:0] rs_addr;
  logic [NRD-1:0]         rs_used;
  logic                   flush;
  logic                   ext_stall;

  logic [NRD-1:0][SW-1:0] fwd_sel,   fwd_sel_c2;
  logic                   stall_dec, stall_dec_c2;
  logic                   bubble_ex, bubble_ex_c2;
  logic [15:0]            lu_count;
  logic [1:0]             lu_count_c2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_regwrite(issue_regwrite), .issue_memread(issue_memread),
    .rs_addr(rs_addr), .rs_used(rs_used), .flush(flush), .ext_stall(ext_stall),
    .fwd_sel(fwd_sel), .stall_dec(stall_dec), .bubble_ex(bubble_ex),
    .lu_count(lu_count)
  );

  fwd_hazard_unit #(.CW(2)) dut_c2 (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_regwrite(issue_regwrite), .issue_memread(issue_memread),
    .rs_addr(rs_addr), .rs_used(rs_used), .flush(flush), .ext_stall(ext_stall),
    .fwd_sel(fwd_sel_c2), .stall_dec(stall_dec_c2), .bubble_ex(bubble_ex_c2),
    .lu_count(lu_count_c2)
  );

  // ---------------- reference model: what sits in stages 1..NST ----------
  int m_v [1:NST];
  int m_rd[1:NST];
  int m_rw[1:NST];
  int m_mr[1:NST];
  int m_cnt16 = 0;
  int m_cnt2  = 0;

  int e_sel[NRD];
  int e_lu_port[NRD];
  int e_lu, e_stall, e_bubble;

  initial begin
    for (int k = 1; k <= NST; k++) begin
      m_v[k] = 0; m_rd[k] = 0; m_rw[k] = 0; m_mr[k] = 0;
    end
  end

  function automatic int hit(int p, int k);
    return (rs_used[p] && m_v[k] != 0 && m_rw[k] != 0 &&
            m_rd[k] == int'(rs_addr[p]) && m_rd[k] != ZR) ? 1 : 0;
  endfunction

  task automatic model_eval();
    int any_lu;
    any_lu = 0;
    for (int p = 0; p < NRD; p++) begin
      e_sel[p]     = 0;
      e_lu_port[p] = 0;
      for (int k = NST; k >= 1; k--)
        if (hit(p, k) != 0) e_sel[p] = k;
      for (int k = 1; k <= LDL; k++)
        if (hit(p, k) != 0 && m_mr[k] != 0) e_lu_port[p] = 1;
      if (e_lu_port[p] != 0) any_lu = 1;
    end
    e_lu = (issue_valid && any_lu != 0) ? 1 : 0;
    for (int p = 0; p < NRD; p++)
      if (issue_valid && e_lu_port[p] != 0) e_sel[p] = 0;
    e_stall  = (ext_stall || (e_lu != 0 && !flush)) ? 1 : 0;
    e_bubble = (!ext_stall && (e_lu != 0 || flush || !issue_valid)) ? 1 : 0;
  endtask

  task automatic model_update();
    model_eval();
    if (reset) begin
      for (int k = 1; k <= NST; k++) m_v[k] = 0;
      m_cnt16 = 0;
      m_cnt2  = 0;
    end else if (!ext_stall) begin
      for (int k = NST; k >= 2; k--) begin
        m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1];
        m_rw[k] = m_rw[k-1]; m_mr[k] = m_mr[k-1];
      end
      m_v[1]  = (e_bubble != 0) ? 0 : 1;
      m_rd[1] = int'(issue_rd);
      m_rw[1] = int'(issue_regwrite);
      m_mr[1] = int'(issue_memread);
      if (e_lu != 0 && !flush) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
  endtask

  // ---------------- checking ----------------------------------------------
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    model_eval();
    for (int p = 0; p < NRD; p++) begin
      check($sformatf("fwd_sel[%0d]", p), int'(fwd_sel[p]), e_sel[p]);
      check($sformatf("c2_fwd_sel[%0d]", p), int'(fwd_sel_c2[p]), e_sel[p]);
    end
    check("stall_dec", int'(stall_dec), e_stall);
    check("bubble_ex", int'(bubble_ex), e_bubble);
    check("c2_stall_dec", int'(stall_dec_c2), e_stall);
    check("c2_bubble_ex", int'(bubble_ex_c2), e_bubble);
    check("lu_count", int'(lu_count), m_cnt16);
    check("c2_lu_count", int'(lu_count_c2), m_cnt2);
  endtask

  task automatic at_neg();
    @(negedge clk);
    compare_all();
  endtask

  task automatic edge_adv();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic tick();
    at_neg();
    edge_adv();
  endtask

  task automatic set_issue(input logic v, input int rd, input logic rw, input logic mr);
    issue_valid    = v;
    issue_rd       = AW'(rd);
    issue_regwrite = rw;
    issue_memread  = mr;
  endtask

  task automatic set_port(input int p, input logic used, input int addr);
    rs_used[p] = used;
    rs_addr[p] = AW'(addr);
  endtask

  int exp_c2[4];

  initial begin
    exp_c2[0] = 1; exp_c2[1] = 2; exp_c2[2] = 3; exp_c2[3] = 3;

    reset = 1'b1; flush = 1'b0; ext_stall = 1'b0;
    set_issue(1'b0, 0, 1'b0, 1'b0);
    rs_used = '0; rs_addr = '0;
    @(posedge clk); #1;
    tick();

    // First cycle out of reset
    reset = 1'b0;
    at_neg();
    for (int p = 0; p < NRD; p++) check("rst_fwd_sel", int'(fwd_sel[p]), 0);
    check("rst_stall", int'(stall_dec), 0);
    check("rst_bubble", int'(bubble_ex), 1);
    check("rst_lu", int'(lu_count), 0);
    edge_adv();

    // ADD X1 walks through stages 1, 2, 3, then leaves
    set_issue(1'b1, 1, 1'b1, 1'b0);
    tick();
    set_issue(1'b1, 0, 1'b0, 1'b0);
    set_port(0, 1'b1, 1);
    for (int s = 1; s <= 4; s++) begin
      at_neg();
      check("add_x1_walk", int'(fwd_sel[0]), (s <= 3) ? s : 0);
      edge_adv();
    end
    set_port(0, 1'b0, 0);

    // Two in-flight writers of X4: youngest wins
    set_issue(1'b1, 4, 1'b1, 1'b0);
    tick();
    tick();
    set_issue(1'b1, 0, 1'b0, 1'b0);
    set_port(1, 1'b1, 4);
    at_neg();
    check("youngest_x4", int'(fwd_sel[1]), 1);
    edge_adv();
    set_port(1, 1'b0, 0);

    // LDUR X2 followed by a reader of X2
    set_issue(1'b1, 2, 1'b1, 1'b1);
    tick();
    set_issue(1'b1, 9, 1'b1, 1'b0);
    set_port(0, 1'b1, 2);
    at_neg();
    check("lu_stall", int'(stall_dec), 1);
    check("lu_bubble", int'(bubble_ex), 1);
    check("lu_fwd_zero", int'(fwd_sel[0]), 0);
    check("lu_cnt_before", int'(lu_count), 0);
    edge_adv();
    check("lu_cnt_after", int'(lu_count), 1);
    at_neg();
    check("lu_fwd_mem", int'(fwd_sel[0]), 2);
    check("lu_release", int'(stall_dec), 0);
    edge_adv();
    set_port(0, 1'b0, 0);

    // Load-use squashed by a flush in the same cycle
    set_issue(1'b1, 3, 1'b1, 1'b1);
    tick();
    set_issue(1'b1, 9, 1'b1, 1'b0);
    set_port(0, 1'b1, 3);
    flush = 1'b1;
    at_neg();
    check("flush_stall", int'(stall_dec), 0);
    check("flush_bubble", int'(bubble_ex), 1);
    edge_adv();
    check("flush_cnt", int'(lu_count), 1);
    flush = 1'b0;
    set_port(0, 1'b0, 0);

    // Freeze with X5 in stage 1
    set_issue(1'b1, 5, 1'b1, 1'b0);
    tick();
    set_issue(1'b1, 0, 1'b0, 1'b0);
    set_port(2, 1'b1, 5);
    ext_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      at_neg();
      check("frz_fwd", int'(fwd_sel[2]), 1);
      check("frz_stall", int'(stall_dec), 1);
      check("frz_bubble", int'(bubble_ex), 0);
      check("frz_cnt", int'(lu_count), 1);
      edge_adv();
    end
    ext_stall = 1'b0;
    at_neg();
    check("frz_release_fwd", int'(fwd_sel[2]), 1);
    edge_adv();
    set_port(2, 1'b0, 0);

    // Zero-register destination is recorded but never forwarded
    set_issue(1'b1, ZR, 1'b1, 1'b0);
    tick();
    set_issue(1'b1, 0, 1'b0, 1'b0);
    set_port(0, 1'b1, ZR);
    at_neg();
    check("zr_fwd", int'(fwd_sel[0]), 0);
    edge_adv();
    set_port(0, 1'b0, 0);

    // Counter saturation on the 2-bit instance
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_issue(1'b1, 2, 1'b1, 1'b1);
    set_port(0, 1'b1, 2);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i % 2 == 1) check("sat_c2", int'(lu_count_c2), exp_c2[i/2]);
    end
    // Reset while frozen
    tick();                   // leaves the load in stage 1
    ext_stall = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; ext_stall = 1'b0;
    set_issue(1'b1, 0, 1'b0, 1'b0);
    rs_used = '0;
    at_neg();
    for (int p = 0; p < NRD; p++) check("rst_frz_fwd", int'(fwd_sel[p]), 0);
    check("rst_frz_stall", int'(stall_dec), 0);
    check("rst_frz_bubble", int'(bubble_ex), 0);
    check("rst_frz_cnt", int'(lu_count), 0);
    check("rst_frz_cnt_c2", int'(lu_count_c2), 0);
    edge_adv();

    // Randomized traffic over a small register range to provoke matches
    for (int n = 0; n < 600; n++) begin
      int r;
      reset     = ($urandom_range(0, 59) == 0);
      ext_stall = ($urandom_range(0, 5) == 0);
      flush     = ($urandom_range(0, 7) == 0);
      r = $urandom_range(0, 8);
      set_issue(($urandom_range(0, 4) != 0), (r == 8) ? ZR : r,
                $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
      for (int p = 0; p < NRD; p++) begin
        r = $urandom_range(0, 8);
        set_port(p, $urandom_range(0, 3) != 0, (r == 8) ? ZR : r);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fwd_hazard_unit
`default_nettype wire

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter NRD, default 3: number of decode-stage register read ports.
REQ-002 Parameter NST, default 3: forwardable downstream stages; stage 1=EX, 2=MEM, 3=WR.
REQ-003 Parameter AW, default 5: register address width.
REQ-004 Parameter ZR, default 31: zero register; never forwarded, never hazards.
REQ-005 Parameter LD_LAT, default 1: stages (from 1) where a load result is not yet forwardable.
REQ-006 Parameter CW, default 16: hazard counter width.
REQ-007 Clock and reset: one clock; reset is synchronous and active-high.
REQ-008 clk  in  1  rising-edge clock.
REQ-009 reset  in  1  synchronous active-high reset.
REQ-010 issue_valid  in  1  DEC holds a valid instruction.
REQ-011 issue_rd / issue_regwrite / issue_memread  in  AW/1/1  destination, writes-reg, is-load for the DEC instruction.
REQ-012 rs_addr  in  NRD x AW  source register per read port.
REQ-013 rs_used  in  NRD  port actually reads its register.
REQ-014 flush  in  1  squash the DEC instruction (taken branch).
REQ-015 ext_stall  in  1  global pipeline freeze (memory busy).
REQ-016 fwd_sel  out  NRD x SW, SW=$clog2(NST+1)  0=register file, k=forward from stage k.
REQ-017 stall_dec  out  1  hold PC and DEC this cycle.
REQ-018 bubble_ex  out  1  NOP injected into stage 1 at next edge.
REQ-019 lu_count  out  CW  saturating count of load-use bubbles.

Function
REQ-020 Block SHALL keep a shadow pipeline of NST entries {valid, rd, regwrite, memread}, entry k mirroring stage k.
REQ-021 Port p matches entry k when rs_used[p], valid, regwrite, rd==rs_addr[p], rd!=ZR.
REQ-022 fwd_sel[p] SHALL be the lowest matching k (youngest wins), else 0; combinational, zero latency.
REQ-023 Load-use hazard: any port matches entry k<=LD_LAT with memread=1, and issue_valid=1.
REQ-024 stall_dec = ext_stall OR (load-use AND NOT flush).
REQ-025 bubble_ex = NOT ext_stall AND (load-use OR flush OR NOT issue_valid), flush taking priority.
REQ-026 While ext_stall=1 all entries and lu_count SHALL hold.
REQ-027 Otherwise at each edge entry k<=entry k-1 (k>=2); entry 1 <= issue fields with valid=1 if NOT bubble_ex, else valid=0.
REQ-028 fwd_sel SHALL be 0 on any port with a load-use hazard on that port.
REQ-029 lu_count SHALL increment by 1 at each edge where load-use AND NOT flush AND NOT ext_stall; saturate at 2^CW-1.
REQ-030 ZR as destination SHALL be recorded but never match or stall.

Reset
REQ-031 On reset edge: all entries valid=0, lu_count=0; reset dominates ext_stall and flush.
REQ-032 Cycle after reset: fwd_sel=0, stall_dec=ext_stall, bubble_ex=NOT issue_valid.

Structure
REQ-033 Package fwd_pkg SHALL hold the shadow-entry struct, default parameter constants and ZR.
REQ-034 One sub-module fwd_port_match (one entry-list priority match per read port, instantiated NRD times) SHALL exist.

Verification
REQ-035 Issue ADD X1 (rd=1), next cycle rs_addr[0]=1 -> fwd_sel[0]=1; one cycle later -> 2; then 3; then 0.
REQ-036 Stages 1 and 2 both write X4, rs_addr[1]=4 -> fwd_sel[1]=1.
REQ-037 LDUR X2 issued, next DEC reads X2 -> stall_dec=1, bubble_ex=1, lu_count 0->1; following cycle fwd_sel=2, stall_dec=0.
REQ-038 Load-use with flush=1 same cycle -> stall_dec=0, bubble_ex=1, lu_count unchanged.
REQ-039 ext_stall=1 for 3 cycles with X5 in stage 1 -> fwd_sel stays 1, lu_count holds; dest X31 -> fwd_sel=0.
REQ-040 CW=2, four back-to-back load-use events -> lu_count 1,2,3,3; reset mid-stall -> all outputs 0 next cycle.
